// File: rtl/ts_sync_framer.sv
// Byte-wide TS sync framer: hunts for sync bytes at packet spacing, locks,
// and forwards whole packets with a sync strobe and per-byte error flag.
module ts_sync_framer #(
    parameter int          PKT_LEN    = 188,
    parameter logic [7:0]  SYNC_BYTE  = 8'h47,
    parameter int          LOCK_CNT   = 3,
    parameter int          UNLOCK_CNT = 3
) (
    input  logic        ts_clk,
    input  logic        rst,
    input  logic        in_dvalid,
    input  logic [7:0]  in_data,
    input  logic        in_err,
    output logic        fr_ts_sync,
    output logic        fr_ts_dvalid,
    output logic [7:0]  fr_ts_di,
    output logic        fr_ts_derr,
    output logic        locked,
    output logic [15:0] sync_loss_cnt
);

    localparam int CW = $clog2(PKT_LEN);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [BW-1:0] bad_cnt_q, bad_cnt_d;
    logic          pkt_bad_q, pkt_bad_d;
    logic [15:0]   loss_q, loss_d;
    logic          sync_q, sync_d;
    logic          dv_q, dv_d;
    logic [7:0]    di_q, di_d;
    logic          derr_q, derr_d;

    logic [CW-1:0] byte_nxt;
    logic [GW-1:0] good_inc;
    logic [BW-1:0] bad_inc;
    logic          at_sync;
    logic          match;

    assign byte_nxt = (byte_cnt_q == CW'(PKT_LEN - 1)) ? '0
                                                        : byte_cnt_q + CW'(1);
    assign good_inc = good_cnt_q + GW'(1);
    assign bad_inc  = bad_cnt_q + BW'(1);
    assign at_sync  = (byte_cnt_q == '0);
    assign match    = (in_data == SYNC_BYTE) && !in_err;

    always_ff @(posedge ts_clk) begin
        if (rst) begin
            state_q    <= HUNT;
            byte_cnt_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            pkt_bad_q  <= 1'b0;
            loss_q     <= '0;
            sync_q     <= 1'b0;
            dv_q       <= 1'b0;
            di_q       <= '0;
            derr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            pkt_bad_q  <= pkt_bad_d;
            loss_q     <= loss_d;
            sync_q     <= sync_d;
            dv_q       <= dv_d;
            di_q       <= di_d;
            derr_q     <= derr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        pkt_bad_d  = pkt_bad_q;
        loss_d     = loss_q;
        sync_d     = 1'b0;
        dv_d       = 1'b0;
        di_d       = in_data;
        derr_d     = 1'b0;
        if (in_dvalid) begin
            unique case (state_q)
                HUNT: begin
                    if (match) begin
                        byte_cnt_d = CW'(1);
                        good_cnt_d = GW'(1);
                        if (LOCK_CNT == 1) begin
                            state_d   = LOCKED;
                            pkt_bad_d = 1'b0;
                            bad_cnt_d = '0;
                            dv_d      = 1'b1;
                            sync_d    = 1'b1;
                        end else begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    byte_cnt_d = byte_nxt;
                    if (at_sync) begin
                        if (match) begin
                            good_cnt_d = good_inc;
                            if (good_inc == GW'(LOCK_CNT)) begin
                                state_d   = LOCKED;
                                pkt_bad_d = 1'b0;
                                bad_cnt_d = '0;
                                dv_d      = 1'b1;
                                sync_d    = 1'b1;
                            end
                        end else begin
                            // failing byte is not reconsidered as a new candidate
                            state_d    = HUNT;
                            good_cnt_d = '0;
                            byte_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    byte_cnt_d = byte_nxt;
                    dv_d       = 1'b1;
                    derr_d     = in_err | pkt_bad_q;
                    if (at_sync) begin
                        sync_d = 1'b1;
                        if (match) begin
                            bad_cnt_d = '0;
                            pkt_bad_d = 1'b0;
                            derr_d    = in_err;
                        end else if (bad_inc == BW'(UNLOCK_CNT)) begin
                            state_d    = HUNT;
                            dv_d       = 1'b0;
                            sync_d     = 1'b0;
                            derr_d     = 1'b0;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                            pkt_bad_d  = 1'b0;
                            byte_cnt_d = '0;
                            if (loss_q != 16'hFFFF)
                                loss_d = loss_q + 16'd1;
                        end else begin
                            bad_cnt_d = bad_inc;
                            pkt_bad_d = 1'b1;
                            derr_d    = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign fr_ts_sync    = sync_q;
    assign fr_ts_dvalid  = dv_q;
    assign fr_ts_di      = di_q;
    assign fr_ts_derr    = derr_q;
    assign locked        = (state_q == LOCKED);
    assign sync_loss_cnt = loss_q;

endmodule
